data_cache_controller: RTL and testbench
========================================

// Module: data_cache_controller
// PURPOSE
//  Responder side of the core's data-memory request interface (MemRead/MemWrite from the main decoder).
//  - Direct-mapped, read-allocate, write-through, no-write-allocate data cache.
//  - Sits between the single-cycle datapath and word-wide main memory.
//  - Serves read hits combinationally in the same cycle.
//  - Stalls the core with cpu_stall during line refills and write-through transfers.
// PARAMETERS
//  ADDR_W          32   byte-address width
//  DATA_W          32   word width
//  LINES           32   number of cache lines (power of 2)
//  WORDS_PER_LINE  4    words per line (power of 2, >=2)
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       synchronous reset, active-high
//  cpu_mem_read  in   1       load request (MemRead)
//  cpu_mem_write in   1       store request (MemWrite)
//  cpu_addr      in   ADDR_W  byte address; bits[1:0] ignored
//  cpu_wdata     in   DATA_W  store data
//  cpu_rdata     out  DATA_W  load data; valid when read && !cpu_stall
//  cpu_stall     out  1       freeze PC/regfile while high
//  mem_req       out  1       main-memory request
//  mem_we        out  1       1 = write, 0 = read
//  mem_addr      out  ADDR_W  word-aligned byte address
//  mem_wdata     out  DATA_W  write data
//  mem_rdata     in   DATA_W  read data; valid with mem_ready
//  mem_ready     in   1       transfer complete this cycle
// BEHAVIOUR
//  - Address split: [1:0] byte, then word offset (log2 WORDS_PER_LINE bits), then index (log2 LINES bits); tag = rest.
//  - Reset: state=IDLE, all valid bits cleared, word_cnt=0.
//    While rst is high: mem_req=0, cpu_stall=0, cpu_rdata=0. Data/tag arrays are not cleared.
//  - States:
//    - IDLE
//      - write (priority over read) -> WRITE_THRU, stall=1.
//      - read hit -> stall=0, rdata = array word (combinational).
//      - read miss -> REFILL with word_cnt=0, stall=1.
//      - No request -> stall=0.
//    - REFILL: mem_req=1, mem_we=0, mem_addr={tag,index,word_cnt,2'b00}.
//      - On mem_ready: write mem_rdata into word word_cnt; word_cnt++.
//      - On last word: set tag and valid; -> IDLE.
//      - The read then hits next cycle and stall drops. Refill latency = sum of memory latencies + 1.
//    - WRITE_THRU: mem_req=1, mem_we=1, mem_addr={cpu_addr[ADDR_W-1:2],2'b00}, mem_wdata=cpu_wdata.
//      - On mem_ready: if hit, update the cached word; -> WRITE_DONE.
//    - WRITE_DONE: stall=0 for exactly one cycle, so the core retires the store; -> IDLE.
//  - Handshake rules:
//    - mem_req/mem_we/mem_addr/mem_wdata stay stable until mem_ready is sampled high.
//    - mem_ready is ignored when mem_req=0.
//    - Zero-wait memory (mem_ready tied high) must work.
//  - Core inputs are held stable by the core while cpu_stall=1. The controller does not re-sample them mid-transaction.
//  - Read and write both asserted: treated as a write.
//  - Reset mid-REFILL: the line stays invalid and the partial fill is discarded. mem_req drops in the reset cycle; memory must tolerate the abandoned transfer.
//  - Reset mid-WRITE_THRU: the store may or may not reach memory; the cache stays consistent because all lines become invalid.
//  - word_cnt wraps to 0 after the last word.
// STRUCTURE
//  - Shared header cache_defs.vh:
//    - state encodings IDLE/REFILL/WRITE_THRU/WRITE_DONE;
//    - derived widths OFFSET_W, INDEX_W, TAG_W.
//  - Sub-module cache_data_array: valid/tag/data storage.
//    - Async read by index/word.
//    - Sync write of one word, plus tag/valid update.
//    - Synchronous clear of all valid bits.
//  - Top level holds the FSM, word_cnt, hit compare and output muxing.
// TESTING (memory model with programmable 0-3 cycle mem_ready delay; mem[a] = a ^ 0xA5A5A5A5 unless written)
//  1. After reset, read 0x40 -> stall; mem reads at 0x40,0x44,0x48,0x4C. Stall low the cycle after the 4th mem_ready; rdata = 0xA5A5A5E5.
//  2. Then read 0x44 -> hit: stall=0 the same cycle, no mem_req, rdata = 0xA5A5A5E1.
//  3. Write 0x48 = 0xDEADBEEF -> one mem write at 0x48, then one WRITE_DONE cycle with stall=0. Read 0x48 hits and returns 0xDEADBEEF.
//  4. Write miss 0x200 = 0x12345678 -> mem write only, no allocate. Read 0x200 misses, refills 0x200-0x20C, returns 0x12345678.
//  5. Conflict: read 0x40, then read 0x240 (same index 4) -> the second refills. Read 0x40 again misses.
//  6. rst for 1 cycle during REFILL after 2 words -> mem_req=0 next cycle. Read 0x40 misses again with a full 4-word refill.

Source files
------------

// File: rtl/data_cache_controller_pkg.sv
// Shared definitions for the data cache controller.
// This file holds the FSM state encoding and the default geometry.
package data_cache_controller_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REFILL     = 2'd1,
    WRITE_THRU = 2'd2,
    WRITE_DONE = 2'd3
  } state_t;

  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_LINES          = 32;
  localparam int DEF_WORDS_PER_LINE = 4;

endpackage

// File: rtl/cache_data_array.sv
// Valid/tag/data storage for the direct-mapped cache.
// Reads are asynchronous. Writes are synchronous. Valid bits have a synchronous clear.
module cache_data_array
  import data_cache_controller_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 2,
  parameter int TAG_W    = 25
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [INDEX_W-1:0]  index,
  input  logic [OFFSET_W-1:0] rd_word,
  output logic                rd_valid,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [DATA_W-1:0]   rd_data,
  input  logic                word_we,
  input  logic [OFFSET_W-1:0] wr_word,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                line_we,
  input  logic [TAG_W-1:0]    wr_tag
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]  valid_bits;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES << OFFSET_W];

  assign rd_valid = valid_bits[index];
  assign rd_tag   = tag_mem[index];
  assign rd_data  = data_mem[{index, rd_word}];

  always_ff @(posedge clk) begin
    if (clr) begin
      valid_bits <= '0;
    end else if (line_we) begin
      valid_bits[index] <= 1'b1;
    end
  end

  // Tag and data contents survive reset; only the valid bits are cleared.
  always_ff @(posedge clk) begin
    if (line_we) tag_mem[index] <= wr_tag;
    if (word_we) data_mem[{index, wr_word}] <= wr_data;
  end

endmodule

// File: rtl/data_cache_controller.sv
// Direct-mapped, read-allocate, write-through, no-write-allocate data cache.
// Read hits are served combinationally. The core is stalled during refills and write-throughs.
module data_cache_controller
  import data_cache_controller_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int LINES          = DEF_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_mem_read,
  input  logic              cpu_mem_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output state_t            dbg_state
);

  localparam int OFFSET_W = $clog2(WORDS_PER_LINE);
  localparam int INDEX_W  = $clog2(LINES);
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W - 2;
  localparam logic [OFFSET_W-1:0] LAST_WORD = OFFSET_W'(WORDS_PER_LINE - 1);

  state_t              state, state_next;
  logic [OFFSET_W-1:0] word_cnt, word_cnt_next;

  logic [OFFSET_W-1:0] addr_word;
  logic [INDEX_W-1:0]  addr_index;
  logic [TAG_W-1:0]    addr_tag;
  logic                unused_byte_bits;

  assign addr_word        = cpu_addr[2 +: OFFSET_W];
  assign addr_index       = cpu_addr[2 + OFFSET_W +: INDEX_W];
  assign addr_tag         = cpu_addr[ADDR_W-1 -: TAG_W];
  assign unused_byte_bits = ^cpu_addr[1:0];

  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [DATA_W-1:0]   rd_data;
  logic                hit;
  logic                word_we, line_we;
  logic [OFFSET_W-1:0] wr_word;
  logic [DATA_W-1:0]   wr_data;

  assign hit = rd_valid && (rd_tag == addr_tag);

  cache_data_array #(
    .DATA_W  (DATA_W),
    .INDEX_W (INDEX_W),
    .OFFSET_W(OFFSET_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk     (clk),
    .clr     (rst),
    .index   (addr_index),
    .rd_word (addr_word),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .word_we (word_we),
    .wr_word (wr_word),
    .wr_data (wr_data),
    .line_we (line_we),
    .wr_tag  (addr_tag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      word_cnt <= '0;
    end else begin
      state    <= state_next;
      word_cnt <= word_cnt_next;
    end
  end

  // Memory handshake: a request (mem_req with mem_we/mem_addr/mem_wdata) is held
  // unchanged until mem_ready is sampled high on a rising edge; that edge completes it.
  always_comb begin
    state_next    = state;
    word_cnt_next = word_cnt;
    cpu_stall     = 1'b0;
    cpu_rdata     = rd_data;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    word_we       = 1'b0;
    line_we       = 1'b0;
    wr_word       = addr_word;
    wr_data       = cpu_wdata;
    case (state)
      IDLE: begin
        if (cpu_mem_write) begin
          cpu_stall  = 1'b1;
          state_next = WRITE_THRU;
        end else if (cpu_mem_read && !hit) begin
          cpu_stall     = 1'b1;
          word_cnt_next = '0;
          state_next    = REFILL;
        end
      end
      REFILL: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = {addr_tag, addr_index, word_cnt, 2'b00};
        if (mem_ready) begin
          word_we       = 1'b1;
          wr_word       = word_cnt;
          wr_data       = mem_rdata;
          word_cnt_next = word_cnt + OFFSET_W'(1);
          if (word_cnt == LAST_WORD) begin
            line_we    = 1'b1;
            state_next = IDLE;
          end
        end
      end
      WRITE_THRU: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {cpu_addr[ADDR_W-1:2], 2'b00};
        mem_wdata = cpu_wdata;
        if (mem_ready) begin
          word_we    = hit;
          state_next = WRITE_DONE;
        end
      end
      WRITE_DONE: state_next = IDLE;
      default:    state_next = IDLE;
    endcase
    if (rst) begin
      cpu_stall = 1'b0;
      cpu_rdata = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      word_we   = 1'b0;
      line_we   = 1'b0;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_data_cache_controller.sv
// Self-checking bench for data_cache_controller: directed scenarios plus randomized traffic
// against a line-level cache model and a variable-latency memory.
module tb_data_cache_controller;
  import data_cache_controller_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_mem_read, cpu_mem_write;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall, mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  state_t      dbg_state;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_cache_controller dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_mem_read (cpu_mem_read),
    .cpu_mem_write(cpu_mem_write),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_stall    (cpu_stall),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .dbg_state    (dbg_state)
  );

  // Main memory with a random 0..max_delay cycle latency per transfer.
  logic [31:0] mem_img [logic [31:0]];
  logic [64:0] act_q [$];
  int          max_delay = 3;
  int          wait_cnt = -1;
  int          last_ready_cyc = 0;
  bit          saw_req = 0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return mem_img.exists(a) ? mem_img[a] : (a ^ 32'hA5A5A5A5);
  endfunction

  always @(negedge clk) begin
    if (mem_req) saw_req = 1'b1;
    if (!mem_req) begin
      mem_ready = 1'b0;
      wait_cnt  = -1;
    end else begin
      if (wait_cnt < 0) wait_cnt = $urandom_range(0, max_delay);
      if (wait_cnt == 0) begin
        mem_ready      = 1'b1;
        last_ready_cyc = cyc;
        wait_cnt       = -1;
        if (mem_we) begin
          mem_img[mem_addr] = mem_wdata;
          act_q.push_back({1'b1, mem_addr, mem_wdata});
        end else begin
          mem_rdata = mem_val(mem_addr);
          act_q.push_back({1'b0, mem_addr, mem_rdata});
        end
      end else begin
        mem_ready = 1'b0;
        wait_cnt--;
      end
    end
  end

  // Reference model: line-granular valid/tag per index and the expected memory image.
  bit          ref_valid [32];
  logic [31:0] ref_tag [32];
  logic [31:0] ref_img [logic [31:0]];

  function automatic logic [31:0] ref_val(input logic [31:0] a);
    return ref_img.exists(a) ? ref_img[a] : (a ^ 32'hA5A5A5A5);
  endfunction

  task automatic ref_invalidate();
    for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;
  endtask

  task automatic do_op(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output int gap, output int log_bad,
                       output int n_exp, output bit timeout);
    logic [64:0] exp_q [$];
    logic [31:0] wa, lb;
    int idx, n;
    wa  = {addr[31:2], 2'b00};
    idx = int'((addr >> 4) % 32);
    if (wr) begin
      exp_q.push_back({1'b1, wa, wdata});
      ref_img[wa] = wdata;
    end else if (rd && !(ref_valid[idx] && ref_tag[idx] == (addr >> 9))) begin
      lb = addr & ~32'hF;
      for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, lb + 32'(4 * k), ref_val(lb + 32'(4 * k))});
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = addr >> 9;
    end
    n_exp = exp_q.size();
    act_q.delete();
    saw_req       = 1'b0;
    cpu_mem_write = wr;
    cpu_mem_read  = rd;
    cpu_addr      = addr;
    cpu_wdata     = wdata;
    n = 0;
    timeout = 1'b0;
    forever begin
      @(negedge clk);
      if (!cpu_stall) break;
      n++;
      if (n > 64) begin
        timeout = 1'b1;
        break;
      end
    end
    rdata = cpu_rdata;
    gap   = cyc - last_ready_cyc;
    @(posedge clk);
    #1;
    cpu_mem_write = 1'b0;
    cpu_mem_read  = 1'b0;
    log_bad = (act_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      if (act_q[i] !== exp_q[i]) log_bad++;
  endtask

  logic [31:0] rd_v;
  int          gap_v, bad_v, nexp_v;
  bit          to_v;

  task automatic test_reset();
    rst = 1'b1;
    cpu_mem_read = 1'b1;
    cpu_addr = 32'h40;
    @(posedge clk);
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got=%b want=0", mem_req); else passed++;
    checks++; if (cpu_stall !== 1'b0) $display("FAIL reset_stall got=%b want=0", cpu_stall); else passed++;
    checks++; if (cpu_rdata !== 32'h0) $display("FAIL reset_rdata got=%h want=0", cpu_rdata); else passed++;
    checks++; if (dbg_state !== IDLE) $display("FAIL reset_state got=%0d want=%0d", dbg_state, IDLE); else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_mem_read = 1'b0;
    ref_invalidate();
  endtask

  task automatic test_refill();
    do_op(0, 1, 32'h40, 32'h0, rd_v, gap_v, bad_v, nexp_v, to_v);
    checks++; if (to_v !== 1'b0) $display("FAIL refill_timeout got=%b want=0", to_v); else passed++;
    checks++; if (rd_v !== 32'hA5A5A5E5) $display("FAIL refill_rdata got=%h want=a5a5a5e5", rd_v); else passed++;
    checks++; if (bad_v !== 0) $display("FAIL refill_mem_log bad_entries=%0d want=0", bad_v); else passed++;
    checks++; if (gap_v !== 1) $display("FAIL refill_stall_release got=%0d want=1", gap_v); else passed++;
  endtask

  task automatic test_hit();
    do_op(0, 1, 32'h44, 32'h0, rd_v, gap_v, bad_v, nexp_v, to_v);
    checks++; if (rd_v !== 32'hA5A5A5E1) $display("FAIL hit_rdata got=%h want=a5a5a5e1", rd_v); else passed++;
    checks++; if (saw_req !== 1'b0) $display("FAIL hit_no_req got=%b want=0", saw_req); else passed++;
    checks++; if (to_v !== 1'b0) $display("FAIL hit_stall got=%b want=0", to_v); else passed++;
  endtask

  task automatic test_write_hit();
    do_op(1, 0, 32'h48, 32'hDEADBEEF, rd_v, gap_v, bad_v, nexp_v, to_v);
    checks++; if (bad_v !== 0) $display("FAIL wr_hit_mem_log bad_entries=%0d want=0", bad_v); else passed++;
    checks++; if (gap_v !== 1) $display("FAIL wr_hit_done_cycle got=%0d want=1", gap_v); else passed++;
    do_op(0, 1, 32'h48, 32'h0, rd_v, gap_v, bad_v, nexp_v, to_v);
    checks++; if (rd_v !== 32'hDEADBEEF) $display("FAIL wr_hit_readback got=%h want=deadbeef", rd_v); else passed++;
    checks++; if (saw_req !== 1'b0) $display("FAIL wr_hit_readback_req got=%b want=0", saw_req); else passed++;
  endtask

  task automatic test_write_miss();
    do_op(1, 0, 32'h200, 32'h12345678, rd_v, gap_v, bad_v, nexp_v, to_v);
    checks++; if (bad_v !== 0) $display("FAIL wr_miss_mem_log bad_entries=%0d want=0", bad_v); else passed++;
    do_op(0, 1, 32'h200, 32'h0, rd_v, gap_v, bad_v, nexp_v, to_v);
    checks++; if (bad_v !== 0) $display("FAIL wr_miss_refill_log bad_entries=%0d want=0", bad_v); else passed++;
    checks++; if (rd_v !== 32'h12345678) $display("FAIL wr_miss_readback got=%h want=12345678", rd_v); else passed++;
  endtask

  task automatic test_conflict();
    do_op(0, 1, 32'h40, 32'h0, rd_v, gap_v, bad_v, nexp_v, to_v);
    checks++; if (saw_req !== 1'b0) $display("FAIL conflict_first_hit got=%b want=0", saw_req); else passed++;
    do_op(0, 1, 32'h240, 32'h0, rd_v, gap_v, bad_v, nexp_v, to_v);
    checks++; if (bad_v !== 0) $display("FAIL conflict_refill_log bad_entries=%0d want=0", bad_v); else passed++;
    checks++; if (rd_v !== 32'hA5A5A7E5) $display("FAIL conflict_rdata got=%h want=a5a5a7e5", rd_v); else passed++;
    do_op(0, 1, 32'h40, 32'h0, rd_v, gap_v, bad_v, nexp_v, to_v);
    checks++; if (saw_req !== 1'b1) $display("FAIL conflict_evicted_miss got=%b want=1", saw_req); else passed++;
    checks++; if (bad_v !== 0) $display("FAIL conflict_evicted_log bad_entries=%0d want=0", bad_v); else passed++;
  endtask

  task automatic test_reset_mid_refill();
    int n;
    do_op(0, 1, 32'h240, 32'h0, rd_v, gap_v, bad_v, nexp_v, to_v);
    act_q.delete();
    cpu_mem_read = 1'b1;
    cpu_addr     = 32'h40;
    n = 0;
    while (act_q.size() < 2 && n < 64) begin
      @(posedge clk);
      n++;
    end
    checks++; if (act_q.size() < 2) $display("FAIL midreset_progress got=%0d want=2", act_q.size()); else passed++;
    #1;
    rst = 1'b1;
    cpu_mem_read = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) $display("FAIL midreset_mem_req got=%b want=0", mem_req); else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ref_invalidate();
    do_op(0, 1, 32'h40, 32'h0, rd_v, gap_v, bad_v, nexp_v, to_v);
    checks++; if (bad_v !== 0) $display("FAIL midreset_refill_log bad_entries=%0d want=0", bad_v); else passed++;
    checks++; if (rd_v !== 32'hA5A5A5E5) $display("FAIL midreset_rdata got=%h want=a5a5a5e5", rd_v); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] a, wd;
    int op;
    for (int t = 0; t < 100; t++) begin
      max_delay = (t < 30) ? 0 : int'($urandom_range(0, 3));
      a  = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 4) |
           (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      wd = $urandom;
      op = $urandom_range(0, 2);
      do_op(op != 0, op != 1, a, wd, rd_v, gap_v, bad_v, nexp_v, to_v);
      checks++; if (to_v !== 1'b0 || bad_v !== 0)
        $display("FAIL rand_txn op=%0d addr=%h timeout=%b bad_entries=%0d want=0/0", op, a, to_v, bad_v);
      else passed++;
      if (op == 0) begin
        checks++; if (rd_v !== ref_val({a[31:2], 2'b00}))
          $display("FAIL rand_rdata addr=%h got=%h want=%h", a, rd_v, ref_val({a[31:2], 2'b00}));
        else passed++;
      end
      if (nexp_v > 0) begin
        checks++; if (gap_v !== 1) $display("FAIL rand_stall_release addr=%h got=%0d want=1", a, gap_v); else passed++;
      end else begin
        checks++; if (saw_req !== 1'b0) $display("FAIL rand_hit_req addr=%h got=%b want=0", a, saw_req); else passed++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    cpu_mem_read = 1'b0;
    cpu_mem_write = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    ref_invalidate();
    test_reset();
    test_refill();
    test_hit();
    test_write_hit();
    test_write_miss();
    test_conflict();
    test_reset_mid_refill();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
